// File: rtl/word_serializer.sv
// Reads a block of words from a synchronous RAM and streams each word out as
// CHUNK_W-bit chunks over a valid/ready handshake.
module word_serializer #(
    parameter int WORD_W    = 32,
    parameter int CHUNK_W   = 8,
    parameter int ADDR_W    = 5,
    parameter int LSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_re,
    input  logic [WORD_W-1:0]   mem_rdata,
    output logic [CHUNK_W-1:0]  chunk_out,
    output logic                chunk_valid,
    input  logic                chunk_ready,
    output logic                busy,
    output logic                done
);

    localparam int NCHUNK = WORD_W / CHUNK_W;
    localparam int IDX_W  = $clog2(NCHUNK);

    typedef enum logic [2:0] {IDLE, READ, CAPT, SHIFT, DONE} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [ADDR_W:0]                 rem_q, rem_d;
    logic [NCHUNK-1:0][CHUNK_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [IDX_W-1:0]                sel;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        word_d  = word_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = word_count;
                    state_d = (word_count == '0) ? DONE : READ;
                end
            end
            READ: state_d = CAPT;
            CAPT: begin
                word_d  = mem_rdata;
                idx_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (chunk_ready) begin
                    if (idx_q == IDX_W'(NCHUNK - 1)) begin
                        rem_d = rem_q - (ADDR_W+1)'(1);
                        // Address wraps naturally at the top of the RAM.
                        if (rem_q > (ADDR_W+1)'(1)) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = READ;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs decode straight from flops, so reset clears them asynchronously.
    always_comb begin
        sel       = (LSB_FIRST != 0) ? idx_q : IDX_W'(NCHUNK - 1) - idx_q;
        chunk_out = word_q[sel];
    end

    assign mem_addr    = addr_q;
    assign mem_re      = (state_q == READ);
    assign chunk_valid = (state_q == SHIFT);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

endmodule
